// File: rtl/uart_pkg.sv
// uart_pkg: declarations shared by the UART receiver (and the transmitter).
//   DATA_BITS       : bits per character.
//   uart_rx_state_t : receiver FSM states. PARITY exists only when
//                     UART_RX_PARITY_EN is defined.
//   calc_div()      : rounded clock cycles per oversample tick.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_rx_state_t;

  // round(clk_hz / (baud * ovs)); never returns less than 1.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int den;
    int q;
    den = baud * ovs;
    q   = (clk_hz + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV
// clocks. 'clear' restarts the count so the next tick lands DIV cycles later,
// letting the receiver phase-align sampling to a start edge.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  restart the divider
//   tick  out high for one cycle when the count reaches DIV-1
module uart_baud_tick #(
  parameter int DIV = 326
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)     cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // With DIV=1 the counter sits at 0 and the tick is permanently high.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver, 8N1 by default.
// Define UART_RX_PARITY_EN for 8E1 (one even-parity bit after the data).
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous serial line, idles high
//   rx_data   out  received byte, stable while rx_valid
//   rx_valid  out  byte available, held until rx_ready
//   rx_ready  in   consumer accept
//   frame_err out  one-cycle pulse: bad stop bit (or parity mismatch)
//   overrun   out  one-cycle pulse: good byte dropped, previous unaccepted
//   busy      out  FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = calc_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] S_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     B_LAST = 3'(DATA_BITS - 1);

  // Two-flop synchroniser plus one delay stage for edge detection.
  logic sync1, rxs, rxs_d;

  always_ff @(posedge clk) begin
    if (rst) {sync1, rxs, rxs_d} <= 3'b111;
    else     {sync1, rxs, rxs_d} <= {rx, sync1, rxs};
  end

  uart_rx_state_t       state;
  logic [SCW-1:0]       scnt;
  logic [2:0]           bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, fall, clear, stop_ok;

  assign fall  = rxs_d & ~rxs;
  assign clear = (state == IDLE) & fall;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign stop_ok = rxs & ~par_err;
`else
  assign stop_ok = rxs;
`endif

  // scnt is restarted at the start-bit midpoint, so from then on every
  // counter wrap (scnt == S_LAST) falls on the middle of the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            scnt  <= '0;
            bidx  <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (scnt == S_MID) begin
              scnt <= '0;
              if (!rxs) begin
                state <= DATA;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (scnt == S_LAST) begin
              scnt  <= '0;
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              bidx  <= bidx + 1'b1;
              if (bidx == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (scnt == S_LAST) begin
              scnt    <= '0;
              // Even parity: data ones plus parity bit must be even.
              par_err <= rxs ^ (^shreg);
              state   <= STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (scnt == S_LAST) begin
              scnt  <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              if (stop_ok) begin
                // Accepting the old byte this cycle frees the slot.
                if (rx_valid && !rx_ready) begin
                  overrun <= 1'b1;
                end else begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Stimulus pushes expected events (byte delivered, frame error, overrun)
// into a queue; a monitor pops one entry for each event the DUT shows.
// Define UART_RX_PARITY_EN to build and exercise the 8E1 variant.
module tb_uart_rx;

  localparam int BIT = 16;
  localparam int EV_DATA = 0;
  localparam int EV_FE   = 1;
  localparam int EV_OV   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  uart_rx #(
    .CLK_HZ     (16_000_000),
    .BAUD       (1_000_000),
    .OVERSAMPLE (16),
    .DIV        (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic check_event(input int kind, input logic [7:0] data, input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind=%0d data=%02h, none expected", name, kind, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == EV_DATA && e.data !== data)) begin
        errors++;
        $display("FAIL %s: got kind=%0d data=%02h expected kind=%0d data=%02h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    bit pv;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        // New byte: valid rose, or old byte accepted at this edge and valid stayed.
        if (rx_valid && (!pv || rx_ready)) check_event(EV_DATA, rx_data, "sb_data");
        if (frame_err) begin
          fe_seen++;
          check_event(EV_FE, 8'h00, "sb_frame_err");
        end
        if (overrun) check_event(EV_OV, 8'h00, "sb_overrun");
      end
      pv = rx_valid;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  // Leaves the stop level on the line; caller decides its duration.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ ~par_ok);
`endif
    rx = stop_bit;
  endtask

  // sel: 0 rx_valid, 1 overrun, 2 busy, 3 frame_err
  task automatic wait_for(input int sel, input int budget, input string name);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      case (sel)
        0:       hit = rx_valid;
        1:       hit = overrun;
        2:       hit = busy;
        default: hit = frame_err;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: no event after %0d cycles, expected one", name, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fe0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0x55, consumer always ready: single-cycle valid
    push(EV_DATA, 8'h55);
    send_frame(8'h55, 1'b1, 1'b1);
    wait_for(0, 40, "valid_55");
    chk("busy_at_valid_55", busy, 1'b0);
    chk("frame_err_55", frame_err, 1'b0);
    @(posedge clk);
    #1;
    chk("valid_pulse_55", rx_valid, 1'b0);
    @(negedge clk);
    drive_bit(1'b1);

    // 0xA3 then 0x3C with consumer stalled: overrun, old byte kept
    rx_ready = 1'b0;
    push(EV_DATA, 8'hA3);
    push(EV_OV, 8'h00);
    send_frame(8'hA3, 1'b1, 1'b1);
    wait_for(0, 40, "valid_a3");
    chk("data_a3", rx_data, 8'hA3);
    @(negedge clk);
    repeat (6) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_for(1, 40, "overrun_3c");
    chk("data_kept_at_ovr", rx_data, 8'hA3);
    @(negedge clk);
    repeat (BIT) @(negedge clk);
    chk("data_kept_after_ovr", rx_data, 8'hA3);
    chk("valid_held", rx_valid, 1'b1);
    chk("overrun_pulse", overrun, 1'b0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop_on_accept", rx_valid, 1'b0);
    @(negedge clk);
    repeat (BIT) @(negedge clk);

    // 4-clock glitch: start rejected at mid-bit
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    wait_for(2, 10, "glitch_busy");
    @(negedge clk);
    repeat (30) @(negedge clk);
    chk("glitch_idle", busy, 1'b0);
    chk("glitch_no_valid", rx_valid, 1'b0);

    // 0xF0 with bad stop bit, then a long break
    fe0 = fe_seen;
    push(EV_FE, 8'h00);
    send_frame(8'hF0, 1'b0, 1'b1);
    repeat (40 * BIT) @(negedge clk);
    chk("break_no_retrigger", busy, 1'b0);
    chk("break_one_fe", fe_seen - fe0, 1);
    chk("break_no_valid", rx_valid, 1'b0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("break_release_idle", busy, 1'b0);

    // Reset during bit 3 of 0x81, then a clean 0x7E
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h81 >> i));
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_valid", rx_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    push(EV_DATA, 8'h7E);
    send_frame(8'h7E, 1'b1, 1'b1);
    wait_for(0, 40, "valid_7e");
    @(negedge clk);
    repeat (BIT) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x07: correct parity (1) delivered, wrong parity (0) rejected
    push(EV_DATA, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_for(0, 40, "valid_par_ok");
    @(negedge clk);
    repeat (BIT) @(negedge clk);
    push(EV_FE, 8'h00);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_for(3, 40, "fe_par_bad");
    @(negedge clk);
    repeat (BIT) @(negedge clk);
    chk("par_bad_no_valid", rx_valid, 1'b0);
`endif

    repeat (20) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the existing `uart_tx`. Deserialises 8N1 asynchronous frames (8E1 with the optional feature) from the `UART_RX` pin into bytes.
- Bytes are presented on a valid/ready handshake to the matrix-multiplication control logic.
- Runs directly on the system clock, using an internal oversampling tick. No external divided clock is needed.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- OVERSAMPLE, 16: samples per bit; must be even and >= 8.
- DIV, round(CLK_HZ/(BAUD*OVERSAMPLE)): clock cycles per sample tick (326 at defaults); must be >= 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready on a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0 (or parity mismatch when the feature is enabled).
- overrun  out  1  one-cycle pulse: a good frame completed while the previous byte was still unaccepted.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0. Synchroniser flops reset to 1. FSM resets to IDLE and all counters to 0.
- rx passes through a 2-flop synchroniser; rxs is its output and rxs_d is rxs delayed one cycle. Only rxs/rxs_d are used downstream.
- Tick generator: counts 0..DIV-1 and pulses tick for one cycle at DIV-1. It is reset to 0 on start-edge detection, so sampling is phase-aligned to the edge.
- Sample counter scnt counts 0..OVERSAMPLE-1, advancing on tick. Mid-bit point = scnt==OVERSAMPLE/2-1.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE -> START on a falling edge (rxs_d=1 & rxs=0). scnt=0, bit index=0.
  - START, at mid-bit: rxs=0 -> restart scnt and go to DATA; rxs=1 -> back to IDLE (glitch rejected, no pulses).
  - DATA: sample rxs every OVERSAMPLE ticks starting one full bit after the start mid-point. Shift in LSB first. After the 8th sample go to PARITY if enabled, else STOP.
  - STOP, at mid-bit: rxs=1 and no parity error -> deliver. Otherwise pulse frame_err and discard the byte. Return to IDLE in the same cycle either way.
- Delivery: rx_valid and rx_data update the cycle after the stop mid-bit tick.
  - If rx_valid=1 and not being accepted that cycle: assert overrun for one cycle, keep the old rx_data/rx_valid, and drop the new byte.
  - If the old byte is accepted in that same cycle: load the new byte, keep rx_valid=1, no overrun.
- Acceptance clears rx_valid the next cycle.
- A line held low (break) causes frame_err once. It cannot retrigger until rx returns high, because IDLE requires an edge.
- rst mid-frame discards the partial frame and returns everything to reset values on the next edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: adds a PARITY state after DATA that samples one even-parity bit at mid-bit. Mismatch is flagged at STOP as frame_err and the byte is discarded.
- Undefined: 8N1 only; the PARITY state, logic and its storage are absent.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (uart_rx_state_t);
  - DATA_BITS=8;
  - helper function calc_div(clk_hz, baud, ovs), shared with `uart_tx` for its divider.
- Sub-module uart_baud_tick (DIV parameter; clk, rst, clear, tick) generates the oversample tick. It is reusable by the transmitter.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16, DIV=1, i.e. 16 clk per bit.
- Send 0x55 as 8N1, rx_ready=1 -> rx_valid pulses one cycle with rx_data=0x55; frame_err=0; busy low after stop mid-bit.
- Send 0xA3 then 0x3C back-to-back, rx_ready=0 -> first: rx_data=0xA3, valid held. Second completes -> overrun one-cycle pulse, rx_data stays 0xA3. Then raise rx_ready -> valid drops the next cycle.
- 4-clk low glitch on idle line -> FSM returns to IDLE at start mid-bit; no valid, no frame_err.
- Frame 0xF0 with stop bit forced 0, then line held low 40 bit times -> exactly one frame_err pulse, no rx_valid, no second detection until rx rises.
- Assert rst during bit 3 of 0x81, then send 0x7E -> outputs at reset values during rst; next frame received correctly as 0x7E.
- With UART_RX_PARITY_EN, send 0x07 with parity 1 (correct) and then parity 0 -> first delivered; second gives frame_err and no rx_valid.
